// File: rtl/seq_ctrl.sv
// Programmable 4-bit pattern sequencer: table loaded over a config port, played under valid/ready.
// Optional SEQ_CTRL_PAUSE_EN adds a pause input that drops out_valid without consuming entries.
module seq_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RPT_W = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [AW-1:0]    cfg_len,
    input  logic [RPT_W-1:0] cfg_rpt,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
`ifdef SEQ_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [AW-1:0]     idx, idx_n;
    logic [RPT_W-1:0]  pass, pass_n;
    logic [AW-1:0]     len_q, len_n;
    logic [RPT_W-1:0]  rpt_q, rpt_n;
    logic [WIDTH-1:0]  out_n;
    logic              out_valid_n;
    logic              busy_n;
    logic              done_n;
    logic              xfer;
    logic              pause_w;
    logic [WIDTH-1:0]  tbl [DEPTH];

`ifdef SEQ_CTRL_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // Pattern table: writable only while not playing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we && (state != RUN)) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            pass      <= '0;
            len_q     <= '0;
            rpt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pass      <= pass_n;
            len_q     <= len_n;
            rpt_q     <= rpt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic; out is presented from the registered index
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        pass_n      = pass;
        len_n       = len_q;
        rpt_n       = rpt_q;
        out_valid_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        xfer        = out_valid & out_ready;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n     = RUN;
                    len_n       = cfg_len;
                    rpt_n       = cfg_rpt;
                    idx_n       = '0;
                    pass_n      = '0;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                end
            end
            RUN: begin
                busy_n      = 1'b1;
                out_valid_n = !pause_w;
                if (xfer) begin
                    if (idx < len_q) begin
                        idx_n = idx + AW'(1);
                    end else begin
                        idx_n = '0;
                        if ((rpt_q != '0) && (pass == rpt_q - RPT_W'(1))) begin
                            state_n     = DONE;
                            out_valid_n = 1'b0;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                        end else if (rpt_q != '0) begin
                            pass_n = pass + RPT_W'(1);
                        end
                    end
                end
                if (stop) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    done_n      = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        out_n = out_valid_n ? tbl[idx_n] : '0;
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Testbench for seq_ctrl: vector table, hand-written corner sequences and randomized runs
// checked against a transaction-level model of the expected output stream.
module tb_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data;
    logic [2:0] cfg_len;
    logic [3:0] cfg_rpt;
    logic       start;
    logic       stop;
    logic       out_ready;
`ifdef SEQ_CTRL_PAUSE_EN
    logic       pause;
`endif
    logic [3:0] out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [3:0] tbl_m [8];
    logic [3:0] exp_q [$];

    typedef struct {
        logic [0:7][3:0]  tbl;
        logic [2:0]       len;
        logic [3:0]       rpt;
        int               mode;
        int               n_exp;
        logic [0:15][3:0] exp_seq;
    } vec_t;

    vec_t vecs [6];

    seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_len   (cfg_len),
        .cfg_rpt   (cfg_rpt),
        .start     (start),
        .stop      (stop),
        .out_ready (out_ready),
`ifdef SEQ_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load_table(input logic [0:7][3:0] vals);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 3'(i);
            cfg_data = vals[i];
            tbl_m[i] = vals[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulse start; config is scrambled afterwards since it must only be sampled on start
    task automatic start_run(input logic [2:0] len, input logic [3:0] rpt);
        @(negedge clk);
        cfg_len = len;
        cfg_rpt = rpt;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cfg_len = 3'($urandom);
        cfg_rpt = 4'($urandom);
    endtask

    // Reference model: a run emits table[0..len] once per pass
    task automatic model_run(input int len, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i <= len; i++) begin
                exp_q.push_back(tbl_m[i]);
            end
        end
    endtask

    // mode 0: ready high, 1: ready toggling, 2: random ready plus stray start pulses
    task automatic play(input int mode, input bit expect_done);
        int         cyc = 0;
        bit         held_v = 1'b0;
        logic [3:0] held = '0;
        while (exp_q.size() != 0 && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) start = 1'($urandom_range(0, 1));
            chk("run_valid", 32'(out_valid), 32'd1);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            if (held_v) chk("hold", 32'(out), 32'(held));
            if (out_valid && out_ready) begin
                chk("xfer_value", 32'(out), 32'(exp_q.pop_front()));
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held   = out;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("transfer_budget", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (expect_done) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_valid", 32'(out_valid), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_out", 32'(out), 32'd0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{tbl: 32'h3719_0000, len: 3'd3, rpt: 4'd2,  mode: 0, n_exp: 8,  exp_seq: 64'h3719_3719_0000_0000};
        vecs[1] = '{tbl: 32'h3719_0000, len: 3'd3, rpt: 4'd2,  mode: 1, n_exp: 8,  exp_seq: 64'h3719_3719_0000_0000};
        vecs[2] = '{tbl: 32'h6000_0000, len: 3'd0, rpt: 4'd3,  mode: 0, n_exp: 3,  exp_seq: 64'h6660_0000_0000_0000};
        vecs[3] = '{tbl: 32'h1234_5678, len: 3'd7, rpt: 4'd1,  mode: 2, n_exp: 8,  exp_seq: 64'h1234_5678_0000_0000};
        vecs[4] = '{tbl: 32'hABCD_EF01, len: 3'd2, rpt: 4'd4,  mode: 1, n_exp: 12, exp_seq: 64'hABCA_BCAB_CABC_0000};
        vecs[5] = '{tbl: 32'hF000_0000, len: 3'd0, rpt: 4'd15, mode: 2, n_exp: 15, exp_seq: 64'hFFFF_FFFF_FFFF_FFF0};

        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_len = '0; cfg_rpt = '0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0;
`ifdef SEQ_CTRL_PAUSE_EN
        pause = 1'b0;
`endif
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;

        // Cleared table after reset: a run plays zeros
        start_run(3'd1, 4'd1);
        model_run(1, 1);
        play(0, 1'b1);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            load_table(vecs[v].tbl);
            start_run(vecs[v].len, vecs[v].rpt);
            for (int k = 0; k < vecs[v].n_exp; k++) exp_q.push_back(vecs[v].exp_seq[k]);
            play(vecs[v].mode, 1'b1);
        end

        // start with stop in IDLE: stop wins
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_valid", 32'(out_valid), 32'd0);

        // Infinite run, then stop
        load_table(32'h5A00_0000);
        start_run(3'd1, 4'd0);
        for (int i = 0; i < 50; i++) exp_q.push_back(tbl_m[i % 2]);
        play(0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_valid", 32'(out_valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_out", 32'(out), 32'd0);
        @(negedge clk);
        chk("stop_done_after", 32'(done), 32'd0);

        // Table writes during RUN are ignored
        load_table(32'h3719_0000);
        start_run(3'd3, 4'd1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'hF;
        repeat (2) @(negedge clk);
        cfg_we = 1'b0;
        chk("we_run_hold", 32'(out), 32'h3);
        model_run(3, 1);
        play(0, 1'b1);
        start_run(3'd3, 4'd1);
        model_run(3, 1);
        play(1, 1'b1);

        // Asynchronous reset mid-run
        start_run(3'd3, 4'd0);
        model_run(2, 1);
        play(0, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) tbl_m[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        start_run(3'd3, 4'd1);
        model_run(3, 1);
        play(0, 1'b1);

`ifdef SEQ_CTRL_PAUSE_EN
        // Pause for three cycles after the second value
        load_table(32'h3719_0000);
        start_run(3'd3, 4'd2);
        out_ready = 1'b1;
        chk("pause_v0", 32'(out), 32'h3);
        @(negedge clk);
        chk("pause_v1", 32'(out), 32'h7);
        pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) pause = 1'b0;
            chk("pause_valid", 32'(out_valid), 32'd0);
            chk("pause_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        exp_q = '{4'h1, 4'h9, 4'h3, 4'h7, 4'h1, 4'h9};
        play(0, 1'b1);
`endif

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            logic [0:7][3:0] vals;
            int len;
            int rpt;
            vals = 32'($urandom);
            len  = $urandom_range(0, 7);
            rpt  = $urandom_range(1, 3);
            load_table(vals);
            start_run(3'(len), 4'(rpt));
            model_run(len, rpt);
            play(2, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
